rv32i_writeback_block: RTL and testbench

- Final pipeline stage: retires results from execute and drives the main register file write port (write_en / wr_reg_num / write_data). This is the write-side counterpart to the decode block's read ports.
- ALU results are written one cycle after acceptance.
- Loads are held until the memory response returns, then byte/half extracted, extended and written.
- Exposes pending-load status so decode can stall on load-use hazards.

---
 rtl/rv32i_writeback_block.sv | 185 ++++++++++++++++++
 tb/tb_rv32i_writeback_block.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_writeback_block.sv
// rtl/rv32i_writeback_block.sv - RV32I writeback stage: ALU retire, load wait/extract, register file write port
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   ex_valid_i / ex_ready_o   handshake from execute; ex_ready_o is high only in IDLE
//   ex_reg_write_i, ex_is_load_i, ex_rd_i, ex_funct3_i, ex_result_i
//                             retiring op: write flag, load flag, rd, load size/sign, result or load address
//   mem_rsp_valid_i, mem_rsp_data_i
//                             load response, word-aligned little-endian data
//   rf_write_en_o, rf_wr_reg_num_o, rf_write_data_o
//                             registered register file write port (num/data are 0 when not writing)
//   pend_load_o, pend_rd_o    load outstanding and its rd, for load-use stall in decode
//   err_misalign_o            one-cycle pulse when a misaligned load is dropped
//   instret_o                 64-bit retired-op counter, present only with WB_INSTRET_EN defined
module rv32i_writeback_block #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid_i,
    output logic            ex_ready_o,
    input  logic            ex_reg_write_i,
    input  logic            ex_is_load_i,
    input  logic [4:0]      ex_rd_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [XLEN-1:0] ex_result_i,
    input  logic            mem_rsp_valid_i,
    input  logic [XLEN-1:0] mem_rsp_data_i,
    output logic            rf_write_en_o,
    output logic [4:0]      rf_wr_reg_num_o,
    output logic [XLEN-1:0] rf_write_data_o,
    output logic            pend_load_o,
    output logic [4:0]      pend_rd_o,
    output logic            err_misalign_o
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret_o
`endif
);

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t          state_q, state_d;

    // captured load context
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic            ld_we_q, ld_we_d;
    logic [2:0]      ld_f3_q, ld_f3_d;
    logic [1:0]      ld_off_q, ld_off_d;

    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_num_q, wr_num_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] rsp_shift;
    logic [XLEN-1:0] load_data;
    logic            misaligned;

`ifdef WB_INSTRET_EN
    logic            retire_d;
    logic [63:0]     instret_q;
`endif

    assign ex_ready_o = (state_q == IDLE);

    // Byte lane selection: shift the addressed byte down to bit 0.
    assign rsp_shift  = mem_rsp_data_i >> {ld_off_q, 3'b000};
    assign misaligned = ((ld_f3_q[1:0] == 2'b01) && ld_off_q[0]) ||
                        ((ld_f3_q == 3'b010) && (ld_off_q != 2'b00));

    always_comb begin
        load_data = '0;
        case (ld_f3_q)
            3'b000:  load_data = {{24{rsp_shift[7]}}, rsp_shift[7:0]};
            3'b001:  load_data = {{16{rsp_shift[15]}}, rsp_shift[15:0]};
            3'b010:  load_data = mem_rsp_data_i;
            3'b100:  load_data = {24'd0, rsp_shift[7:0]};
            3'b101:  load_data = {16'd0, rsp_shift[15:0]};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ld_rd_d   = ld_rd_q;
        ld_we_d   = ld_we_q;
        ld_f3_d   = ld_f3_q;
        ld_off_d  = ld_off_q;
        wr_en_d   = 1'b0;
        wr_num_d  = 5'd0;
        wr_data_d = '0;
        err_d     = 1'b0;
`ifdef WB_INSTRET_EN
        retire_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ex_valid_i) begin
                    if (ex_is_load_i) begin
                        ld_rd_d  = ex_rd_i;
                        ld_we_d  = ex_reg_write_i;
                        ld_f3_d  = ex_funct3_i;
                        ld_off_d = ex_result_i[1:0];
                        state_d  = LOAD_WAIT;
                    end else begin
`ifdef WB_INSTRET_EN
                        retire_d = 1'b1;
`endif
                        if (ex_reg_write_i && (ex_rd_i != 5'd0)) begin
                            wr_en_d   = 1'b1;
                            wr_num_d  = ex_rd_i;
                            wr_data_d = ex_result_i;
                        end
                    end
                end
            end
            LOAD_WAIT: begin
                if (mem_rsp_valid_i) begin
                    state_d = IDLE;
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else begin
`ifdef WB_INSTRET_EN
                        retire_d = 1'b1;
`endif
                        if (ld_we_q && (ld_rd_q != 5'd0)) begin
                            wr_en_d   = 1'b1;
                            wr_num_d  = ld_rd_q;
                            wr_data_d = load_data;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ld_rd_q   <= 5'd0;
            ld_we_q   <= 1'b0;
            ld_f3_q   <= 3'd0;
            ld_off_q  <= 2'd0;
            wr_en_q   <= 1'b0;
            wr_num_q  <= 5'd0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_rd_q   <= ld_rd_d;
            ld_we_q   <= ld_we_d;
            ld_f3_q   <= ld_f3_d;
            ld_off_q  <= ld_off_d;
            wr_en_q   <= wr_en_d;
            wr_num_q  <= wr_num_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= 64'd0;
        end else if (retire_d) begin
            instret_q <= instret_q + 64'd1;
        end
    end
    assign instret_o = instret_q;
`endif

    // pend_* are flop outputs that mirror LOAD_WAIT and its captured rd.
    assign pend_load_o     = (state_q == LOAD_WAIT);
    assign pend_rd_o       = (state_q == LOAD_WAIT) ? ld_rd_q : 5'd0;
    assign rf_write_en_o   = wr_en_q;
    assign rf_wr_reg_num_o = wr_num_q;
    assign rf_write_data_o = wr_data_q;
    assign err_misalign_o  = err_q;

endmodule

// File: tb/tb_rv32i_writeback_block.sv
// tb/tb_rv32i_writeback_block.sv - directed self-checking bench for rv32i_writeback_block
module tb_rv32i_writeback_block;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic        ex_reg_write_i;
    logic        ex_is_load_i;
    logic [4:0]  ex_rd_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_result_i;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        rf_write_en_o;
    logic [4:0]  rf_wr_reg_num_o;
    logic [31:0] rf_write_data_o;
    logic        pend_load_o;
    logic [4:0]  pend_rd_o;
    logic        err_misalign_o;
`ifdef WB_INSTRET_EN
    logic [63:0] instret_o;
    logic [63:0] exp_instret = 64'd0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rv32i_writeback_block #(.XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid_i      (ex_valid_i),
        .ex_ready_o      (ex_ready_o),
        .ex_reg_write_i  (ex_reg_write_i),
        .ex_is_load_i    (ex_is_load_i),
        .ex_rd_i         (ex_rd_i),
        .ex_funct3_i     (ex_funct3_i),
        .ex_result_i     (ex_result_i),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .rf_write_en_o   (rf_write_en_o),
        .rf_wr_reg_num_o (rf_wr_reg_num_o),
        .rf_write_data_o (rf_write_data_o),
        .pend_load_o     (pend_load_o),
        .pend_rd_o       (pend_rd_o),
        .err_misalign_o  (err_misalign_o)
`ifdef WB_INSTRET_EN
        ,
        .instret_o       (instret_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] num, input logic [31:0] data);
        chk({tag, ".we"}, {63'd0, rf_write_en_o}, {63'd0, we});
        chk({tag, ".num"}, {59'd0, rf_wr_reg_num_o}, {59'd0, num});
        chk({tag, ".data"}, {32'd0, rf_write_data_o}, {32'd0, data});
    endtask

    task automatic alu(input logic [4:0] rd, input logic rw, input logic [31:0] res);
        ex_valid_i = 1'b1; ex_is_load_i = 1'b0; ex_reg_write_i = rw;
        ex_rd_i = rd; ex_result_i = res; ex_funct3_i = 3'd0;
        tick();
        ex_valid_i = 1'b0;
    endtask

    // Load accepted, response issued exactly one cycle later, write checked the cycle after.
    task automatic load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rsp,
                        input logic we, input logic [31:0] data, input logic err);
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_reg_write_i = 1'b1;
        ex_rd_i = rd; ex_funct3_i = f3; ex_result_i = addr;
        tick();
        ex_valid_i = 1'b0; ex_is_load_i = 1'b0;
        chk({tag, ".pend_rd"}, {59'd0, pend_rd_o}, {59'd0, rd});
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = rsp;
        tick();
        mem_rsp_valid_i = 1'b0; mem_rsp_data_i = 32'd0;
        chk_wr(tag, we, we ? rd : 5'd0, data);
        chk({tag, ".err"}, {63'd0, err_misalign_o}, {63'd0, err});
        chk({tag, ".ready"}, {63'd0, ex_ready_o}, 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        ex_valid_i = 1'b0; ex_reg_write_i = 1'b0; ex_is_load_i = 1'b0;
        ex_rd_i = 5'd0; ex_funct3_i = 3'd0; ex_result_i = 32'd0;
        mem_rsp_valid_i = 1'b0; mem_rsp_data_i = 32'd0;
        #2;
        chk("rst.ready", {63'd0, ex_ready_o}, 64'd1);
        chk_wr("rst", 1'b0, 5'd0, 32'd0);
        chk("rst.pend", {63'd0, pend_load_o}, 64'd0);
        chk("rst.err", {63'd0, err_misalign_o}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // ALU write, then idle cycle
        alu(5'd5, 1'b1, 32'hDEADBEEF);
        chk_wr("alu", 1'b1, 5'd5, 32'hDEADBEEF);
`ifdef WB_INSTRET_EN
        exp_instret++;
        chk("alu.instret", instret_o, exp_instret);
`endif
        tick();
        chk_wr("alu.idle", 1'b0, 5'd0, 32'd0);

        // back-to-back accepts
        ex_valid_i = 1'b1; ex_is_load_i = 1'b0; ex_reg_write_i = 1'b1;
        ex_rd_i = 5'd7; ex_result_i = 32'h0000_0001;
        tick();
        chk_wr("b2b0", 1'b1, 5'd7, 32'h1);
        ex_rd_i = 5'd8; ex_result_i = 32'h0000_0002;
        tick();
        ex_valid_i = 1'b0;
        chk_wr("b2b1", 1'b1, 5'd8, 32'h2);

        // x0 and reg_write=0 suppression
        alu(5'd0, 1'b1, 32'h1234);
        chk_wr("x0", 1'b0, 5'd0, 32'd0);
        alu(5'd9, 1'b0, 32'h5555);
        chk_wr("nowr", 1'b0, 5'd0, 32'd0);
`ifdef WB_INSTRET_EN
        exp_instret += 4;
        chk("x0.instret", instret_o, exp_instret);
`endif

        // LB sign, response two cycles after accept, stray response in acceptance cycle
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_reg_write_i = 1'b1;
        ex_rd_i = 5'd3; ex_funct3_i = 3'b000; ex_result_i = 32'h102;
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0000_00FF;
        tick();
        ex_valid_i = 1'b0; ex_is_load_i = 1'b0; mem_rsp_valid_i = 1'b0;
        chk("lb.ready0", {63'd0, ex_ready_o}, 64'd0);
        chk("lb.pend0", {63'd0, pend_load_o}, 64'd1);
        chk("lb.pend_rd0", {59'd0, pend_rd_o}, 64'd3);
        chk_wr("lb.wait0", 1'b0, 5'd0, 32'd0);
        tick();
        chk("lb.ready1", {63'd0, ex_ready_o}, 64'd0);
        chk("lb.pend_rd1", {59'd0, pend_rd_o}, 64'd3);
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0080_0000;
        tick();
        mem_rsp_valid_i = 1'b0;
        chk_wr("lb", 1'b1, 5'd3, 32'hFFFFFF80);
        chk("lb.ready", {63'd0, ex_ready_o}, 64'd1);
        chk("lb.pend", {63'd0, pend_load_o}, 64'd0);
        chk("lb.pend_rd", {59'd0, pend_rd_o}, 64'd0);

        load("lhu", 5'd4, 3'b101, 32'h202, 32'hBEEF1234, 1'b1, 32'h0000BEEF, 1'b0);
        load("lw", 5'd6, 3'b010, 32'h100, 32'h11223344, 1'b1, 32'h11223344, 1'b0);
        load("lbu", 5'd12, 3'b100, 32'h103, 32'h80FF0000, 1'b1, 32'h00000080, 1'b0);
        load("lh", 5'd13, 3'b001, 32'h100, 32'h00018001, 1'b1, 32'hFFFF8001, 1'b0);
        load("f3_011", 5'd10, 3'b011, 32'h100, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0);
`ifdef WB_INSTRET_EN
        exp_instret += 6;
        chk("ld.instret", instret_o, exp_instret);
`endif

        // misaligned LW and LHU: dropped, error pulse, counter unchanged
        load("mis_lw", 5'd14, 3'b010, 32'h101, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1);
        tick();
        chk("mis.err_clr", {63'd0, err_misalign_o}, 64'd0);
        load("mis_lhu", 5'd15, 3'b101, 32'h203, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1);
`ifdef WB_INSTRET_EN
        chk("mis.instret", instret_o, exp_instret);
`endif

        // reset during LOAD_WAIT abandons the load
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_reg_write_i = 1'b1;
        ex_rd_i = 5'd11; ex_funct3_i = 3'b010; ex_result_i = 32'h300;
        tick();
        ex_valid_i = 1'b0; ex_is_load_i = 1'b0;
        chk("rm.pend", {63'd0, pend_load_o}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rm.pend_async", {63'd0, pend_load_o}, 64'd0);
        tick();
        rst = 1'b0;
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'hCAFEF00D;
        tick();
        mem_rsp_valid_i = 1'b0;
        chk_wr("rm", 1'b0, 5'd0, 32'd0);
        chk("rm.ready", {63'd0, ex_ready_o}, 64'd1);
        chk("rm.pend_after", {63'd0, pend_load_o}, 64'd0);
        tick();
        chk("rm.we2", {63'd0, rf_write_en_o}, 64'd0);
`ifdef WB_INSTRET_EN
        chk("rm.instret", instret_o, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
